// File: rtl/split_reg_if.sv
// Bus bundle for split_reg: the master request/response and the packed per-slave
// request/response slots.
interface split_reg_if #(
  parameter int unsigned N_SLAVES = 2,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32
);
  localparam int unsigned NsW   = $clog2(N_SLAVES);
  localparam int unsigned ReqW  = 1 + ADDR_W + DATA_W + DATA_W / 8;
  localparam int unsigned SlotW = 1 + ADDR_W - NsW + DATA_W + DATA_W / 8;
  localparam int unsigned RespW = DATA_W + 1;

  logic [ReqW-1:0]           m_req;   // {valid, addr, wdata, wstrb}
  logic [DATA_W:0]           m_resp;  // {rdata, ready}
  logic                      m_err;
  logic [N_SLAVES*SlotW-1:0] s_req;
  logic [N_SLAVES*RespW-1:0] s_resp;

  // Environment side: drives the master request and the slave responses.
  modport master (
    output m_req,
    input  m_resp,
    input  m_err,
    input  s_req,
    output s_resp
  );

  // Splitter side.
  modport slave (
    input  m_req,
    output m_resp,
    output m_err,
    output s_req,
    input  s_resp
  );
endinterface

// File: rtl/split_reg.sv
// Registered one-master to N-slave address splitter. Routing is held for the whole
// transaction; unmapped and timed-out accesses complete with an error response.
module split_reg #(
  parameter int unsigned       N_SLAVES  = 2,
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       P_SLAVES  = ADDR_W - 1,
  parameter int unsigned       TIMEOUT_W = 8,
  parameter logic [DATA_W-1:0] ERR_DATA  = DATA_W'(32'hDEADBEEF)
) (
  input  logic        clk,
  input  logic        rst,
  split_reg_if.slave  bus,
  output logic        busy
);
  localparam int unsigned NsW   = $clog2(N_SLAVES);
  localparam int unsigned SaW   = ADDR_W - NsW;
  localparam int unsigned StrbW = DATA_W / 8;
  localparam int unsigned SlotW = 1 + SaW + DATA_W + StrbW;
  localparam int unsigned RespW = DATA_W + 1;
  localparam int          SelLo = int'(P_SLAVES) - int'(NsW) + 1;
  // Last count value before expiry: 2^TIMEOUT_W-2, so the slave sees 2^TIMEOUT_W-1 cycles.
  localparam logic [TIMEOUT_W-1:0] CntLast = ~TIMEOUT_W'(1);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e               state_q, state_d;
  logic [NsW-1:0]       sel_q, sel_d;
  logic [SaW-1:0]       saddr_q, saddr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [StrbW-1:0]     wstrb_q, wstrb_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic                 err_q, err_d;

  logic                 req_valid;
  logic [ADDR_W-1:0]    req_addr;
  logic [DATA_W-1:0]    req_wdata;
  logic [StrbW-1:0]     req_wstrb;
  logic [NsW-1:0]       req_sel;
  logic [SaW-1:0]       req_saddr;
  logic                 sel_ready;
  logic [DATA_W-1:0]    sel_rdata;

  assign {req_valid, req_addr, req_wdata, req_wstrb} = bus.m_req;
  assign req_sel = req_addr[P_SLAVES -: NsW];

  // Squeeze the select field out of the address; bits above it shift down.
  always_comb begin
    req_saddr = '0;
    for (int i = 0; i < int'(SaW); i++) begin
      req_saddr[i] = (i < SelLo) ? req_addr[i] : req_addr[i+int'(NsW)];
    end
  end

  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < int'(N_SLAVES); i++) begin
      if (sel_q == NsW'(i)) {sel_rdata, sel_ready} = bus.s_resp[i*RespW +: RespW];
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    saddr_d = saddr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (32'(req_sel) < N_SLAVES) begin
            sel_d   = req_sel;
            saddr_d = req_saddr;
            wdata_d = req_wdata;
            wstrb_d = req_wstrb;
            cnt_d   = '0;
            state_d = StBusy;
          end else begin
            rdata_d = ERR_DATA;
            err_d   = 1'b1;
            state_d = StResp;
          end
        end
      end
      StBusy: begin
        // Ready takes priority over a timeout expiring in the same cycle.
        if (sel_ready) begin
          rdata_d = sel_rdata;
          err_d   = 1'b0;
          state_d = StResp;
        end else if (cnt_q == CntLast) begin
          rdata_d = ERR_DATA;
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + TIMEOUT_W'(1);
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      sel_q   <= '0;
      saddr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      saddr_q <= saddr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    bus.s_req = '0;
    for (int i = 0; i < int'(N_SLAVES); i++) begin
      if (state_q == StBusy && sel_q == NsW'(i)) begin
        bus.s_req[i*SlotW +: SlotW] = {1'b1, saddr_q, wdata_q, wstrb_q};
      end
    end
  end

  assign bus.m_resp = (state_q == StResp) ? {rdata_q, 1'b1} : '0;
  assign bus.m_err  = (state_q == StResp) && err_q;
  assign busy       = (state_q != StIdle);
endmodule
